time_ascii_tx: RTL and testbench

TIME_ASCII_TX -- requirements
Module: time_ascii_tx

---
 rtl/time_ascii_tx_pkg.sv | 47 ++++
 rtl/time_ascii_tx_if.sv | 23 ++
 rtl/bcd_nibble_to_ascii.sv | 21 ++
 rtl/time_ascii_tx.sv | 122 ++++++++++++
 tb/tb_time_ascii_tx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/time_ascii_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_ascii_tx_pkg : shared types and ASCII constants for time_ascii_tx |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package time_ascii_tx_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_SEND = 2'd1,
    STATE_DONE = 2'd2
  } state_e;

  localparam int MSG_LEN = 12;
  localparam int IDX_W   = 4;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // Byte slots of the message "HH:MM:SS XM<eol>"
  localparam logic [IDX_W-1:0] IDX_H1  = 4'd0;
  localparam logic [IDX_W-1:0] IDX_H0  = 4'd1;
  localparam logic [IDX_W-1:0] IDX_C1  = 4'd2;
  localparam logic [IDX_W-1:0] IDX_M1  = 4'd3;
  localparam logic [IDX_W-1:0] IDX_M0  = 4'd4;
  localparam logic [IDX_W-1:0] IDX_C2  = 4'd5;
  localparam logic [IDX_W-1:0] IDX_S1  = 4'd6;
  localparam logic [IDX_W-1:0] IDX_S0  = 4'd7;
  localparam logic [IDX_W-1:0] IDX_SP  = 4'd8;
  localparam logic [IDX_W-1:0] IDX_AP  = 4'd9;
  localparam logic [IDX_W-1:0] IDX_MM  = 4'd10;
  localparam logic [IDX_W-1:0] IDX_EOL = 4'd11;

  typedef struct packed {
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } snapshot_t;

endpackage
`default_nettype wire

// File: rtl/time_ascii_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_ascii_tx_if : valid/ready byte stream carrying the ASCII message  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface time_ascii_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/bcd_nibble_to_ascii.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_nibble_to_ascii : one BCD digit to ASCII, '?' for nibbles above 9  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module bcd_nibble_to_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);
  import time_ascii_tx_pkg::*;

  always_comb begin
    if (nibble_i > 4'd9) begin
      ascii_o = ASCII_QMARK;
    end else begin
      ascii_o = ASCII_ZERO + {4'h0, nibble_i};
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_ascii_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_ascii_tx : snapshots a BCD 12-hour time and streams it as ASCII  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module time_ascii_tx #(
  parameter bit         LEADING_BLANK = 1'b0,
  parameter logic [7:0] EOL_CHAR      = 8'h0A
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            pm,
  input  logic [7:0]      hh,
  input  logic [7:0]      mm,
  input  logic [7:0]      ss,
  time_ascii_tx_if.master tx,
  output logic            busy,
  output logic            done
);
  import time_ascii_tx_pkg::*;

  localparam logic [1:0]       IDLE     = STATE_IDLE;
  localparam logic [1:0]       SEND     = STATE_SEND;
  localparam logic [1:0]       DONE     = STATE_DONE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  snapshot_t        snap_q,  snap_d;

  logic       valid;
  logic       accept;
  logic [3:0] nibble_sel;
  logic [7:0] digit_ascii;
  logic [7:0] byte_sel;

  assign valid  = (state_q == SEND);
  assign accept = valid && tx.tx_ready;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = '{pm: pm, hh: hh, mm: mm, ss: ss};
          index_d = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (index_q == LAST_IDX) begin
            index_d = '0;
            state_d = DONE;
          end else begin
            index_d = index_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      snap_q  <= snap_d;
    end
  end

  // Only the six digit slots reach the converter; other slots ignore it.
  always_comb begin
    nibble_sel = 4'h0;
    case (index_q)
      IDX_H1:  nibble_sel = snap_q.hh[7:4];
      IDX_H0:  nibble_sel = snap_q.hh[3:0];
      IDX_M1:  nibble_sel = snap_q.mm[7:4];
      IDX_M0:  nibble_sel = snap_q.mm[3:0];
      IDX_S1:  nibble_sel = snap_q.ss[7:4];
      IDX_S0:  nibble_sel = snap_q.ss[3:0];
      default: nibble_sel = 4'h0;
    endcase
  end

  bcd_nibble_to_ascii u_digit (
    .nibble_i (nibble_sel),
    .ascii_o  (digit_ascii)
  );

  always_comb begin
    byte_sel = digit_ascii;
    case (index_q)
      IDX_H1: begin
        if (LEADING_BLANK && (snap_q.hh[7:4] == 4'h0)) begin
          byte_sel = ASCII_SPACE;
        end
      end
      IDX_C1, IDX_C2: byte_sel = ASCII_COLON;
      IDX_SP:         byte_sel = ASCII_SPACE;
      IDX_AP:         byte_sel = snap_q.pm ? ASCII_P : ASCII_A;
      IDX_MM:         byte_sel = ASCII_M;
      IDX_EOL:        byte_sel = EOL_CHAR;
      default:        byte_sel = digit_ascii;
    endcase
  end

  assign tx.tx_valid = valid;
  assign tx.tx_data  = valid ? byte_sel : 8'h00;
  assign busy        = valid;
  assign done        = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_time_ascii_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_time_ascii_tx : vector table plus randomized streams vs byte model  |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_time_ascii_tx;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        pm;
    logic [87:0] text;   // expected bytes 0..10 with LEADING_BLANK=1
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pm = 1'b0;
  logic       tx_ready = 1'b1;
  logic [7:0] hh = 8'h00;
  logic [7:0] mm = 8'h00;
  logic [7:0] ss = 8'h00;
  logic       busy_b, done_b, busy_z, done_z;

  time_ascii_tx_if ifb ();
  time_ascii_tx_if ifz ();
  assign ifb.tx_ready = tx_ready;
  assign ifz.tx_ready = tx_ready;

  time_ascii_tx #(.LEADING_BLANK(1'b1), .EOL_CHAR(8'h0A)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .tx(ifb), .busy(busy_b), .done(done_b)
  );

  time_ascii_tx #(.LEADING_BLANK(1'b0), .EOL_CHAR(8'h0D)) dut_z (
    .clk(clk), .reset(reset), .start(start), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
    .tx(ifz), .busy(busy_z), .done(done_z)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  bq_t qb, qz;
  int  done_cycs_b[$];
  int  done_cnt_b = 0;
  int  done_cnt_z = 0;
  int  stall_bad  = 0;
  bit  stall_b = 0, stall_z = 0, rst_prev = 0;
  logic [7:0] held_b, held_z;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted-byte capture, stall stability and done bookkeeping.
  always @(negedge clk) begin
    if (ifb.tx_valid && tx_ready) qb.push_back(ifb.tx_data);
    if (ifz.tx_valid && tx_ready) qz.push_back(ifz.tx_data);
    if (stall_b && !rst_prev && !(ifb.tx_valid && ifb.tx_data == held_b)) stall_bad++;
    if (stall_z && !rst_prev && !(ifz.tx_valid && ifz.tx_data == held_z)) stall_bad++;
    stall_b = ifb.tx_valid && !tx_ready;
    stall_z = ifz.tx_valid && !tx_ready;
    held_b  = ifb.tx_data;
    held_z  = ifz.tx_data;
    if (done_b) begin done_cnt_b++; done_cycs_b.push_back(cyc); end
    if (done_z) done_cnt_z++;
    rst_prev = reset;
  end

  function automatic logic [7:0] digit(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h3F;
  endfunction

  function automatic bq_t model_msg(input logic [7:0] h, input logic [7:0] m,
                                    input logic [7:0] s, input logic p,
                                    input bit lb, input logic [7:0] eol);
    bq_t q;
    logic [7:0] f[3];
    f[0] = h; f[1] = m; f[2] = s;
    for (int k = 0; k < 3; k++) begin
      if (k == 0 && lb && (f[k] >> 4) == 8'd0) q.push_back(8'h20);
      else q.push_back(digit(4'(f[k] >> 4)));
      q.push_back(digit(4'(f[k] % 16)));
      if (k < 2) q.push_back(":");
    end
    q.push_back(" ");
    q.push_back(p ? "P" : "A");
    q.push_back("M");
    q.push_back(eol);
    return q;
  endfunction

  function automatic string q2str(input bq_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic check_q(input string name, input bq_t act, input bq_t exp);
    bit ok = (act.size() == exp.size());
    if (ok) foreach (exp[i]) if (act[i] !== exp[i]) ok = 0;
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got [%s] expected [%s]", name, q2str(act), q2str(exp));
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    qb.delete(); qz.delete(); done_cycs_b.delete();
    done_cnt_b = 0; done_cnt_z = 0; stall_bad = 0;
  endtask

  // Present inputs with start high; returns the cycle stamp of the sampling edge.
  task automatic launch(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input logic p, output int t0);
    hh = h; mm = m; ss = s; pm = p; start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int c = 0;
    while (done_cnt_b < target && c < 400) begin tick(); c++; end
    check_val(name, 32'(done_cnt_b >= target), 32'd1);
  endtask

  function automatic int first_done_lat(input int t0);
    if (done_cycs_b.size() == 0) return -1;
    return done_cycs_b[0] - t0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    bq_t  exp, exp2;
    logic [87:0] txt;
    logic [7:0] rh, rm, rs;
    logic rp;
    int t0;
    bit ok;

    vt[0] = '{8'h12, 8'h00, 8'h00, 1'b0, "12:00:00 AM"};
    vt[1] = '{8'h09, 8'h45, 8'h30, 1'b1, " 9:45:30 PM"};
    vt[2] = '{8'h07, 8'h59, 8'h5A, 1'b0, " 7:59:5? AM"};
    vt[3] = '{8'h13, 8'h61, 8'h00, 1'b1, "13:61:00 PM"};
    vt[4] = '{8'h0A, 8'h0B, 8'hC0, 1'b0, " ?:0?:?0 AM"};
    vt[5] = '{8'hF1, 8'h23, 8'h45, 1'b1, "?1:23:45 PM"};
    vt[6] = '{8'h10, 8'h09, 8'h59, 1'b1, "10:09:59 PM"};

    reset = 1'b1;
    repeat (3) tick();
    check_val("reset state b", {ifb.tx_valid, ifb.tx_data, busy_b, done_b}, 32'd0);
    check_val("reset state z", {ifz.tx_valid, ifz.tx_data, busy_z, done_z}, 32'd0);
    reset = 1'b0;
    tick();

    // Table vectors, tx_ready held high.
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      tx_ready = 1'b1;
      launch(vt[i].hh, vt[i].mm, vt[i].ss, vt[i].pm, t0);
      check_val($sformatf("tbl%0d busy/valid after start", i), {busy_b, ifb.tx_valid}, 32'd3);
      wait_done(1, $sformatf("tbl%0d done timeout", i));
      repeat (3) tick();
      exp.delete();
      txt = vt[i].text;
      for (int k = 0; k < 11; k++) exp.push_back(txt[87-8*k -: 8]);
      exp.push_back(8'h0A);
      check_q($sformatf("tbl%0d bytes lb1", i), qb, exp);
      check_q($sformatf("tbl%0d bytes lb0", i),
              qz, model_msg(vt[i].hh, vt[i].mm, vt[i].ss, vt[i].pm, 1'b0, 8'h0D));
      check_val($sformatf("tbl%0d done latency", i), 32'(first_done_lat(t0)), 32'd12);
      check_val($sformatf("tbl%0d done count", i), 32'(done_cnt_b + done_cnt_z), 32'd2);
    end

    // Random stalls, inputs and start toggled every cycle while a message runs.
    for (int r = 0; r < 6; r++) begin
      clear_mon();
      rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom); rp = 1'($urandom);
      launch(rh, rm, rs, rp, t0);
      ok = 0;
      for (int c = 0; c < 400; c++) begin
        if (done_cnt_b != 0) begin ok = 1; break; end
        hh = 8'($urandom); mm = 8'($urandom); ss = 8'($urandom);
        pm = 1'($urandom); start = 1'($urandom);
        tx_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      start = 1'b0;
      tx_ready = 1'b1;
      repeat (4) tick();
      check_val($sformatf("rnd%0d finished", r), 32'(ok), 32'd1);
      check_q($sformatf("rnd%0d bytes lb1", r), qb, model_msg(rh, rm, rs, rp, 1'b1, 8'h0A));
      check_q($sformatf("rnd%0d bytes lb0", r), qz, model_msg(rh, rm, rs, rp, 1'b0, 8'h0D));
      check_val($sformatf("rnd%0d done count", r), 32'(done_cnt_b + done_cnt_z), 32'd2);
      check_val($sformatf("rnd%0d stall stability", r), 32'(stall_bad), 32'd0);
    end

    // start held through SEND and the DONE cycle: one message only.
    clear_mon();
    tx_ready = 1'b1;
    hh = 8'h11; mm = 8'h22; ss = 8'h33; pm = 1'b1; start = 1'b1;
    tick();
    t0 = cyc;
    repeat (13) tick();
    start = 1'b0;
    repeat (6) tick();
    check_val("hold13 done count", 32'(done_cnt_b), 32'd1);
    check_q("hold13 bytes", qb, model_msg(8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 8'h0A));

    // start held one edge longer: second message starts exactly 14 cycles later.
    clear_mon();
    hh = 8'h04; mm = 8'h05; ss = 8'h06; pm = 1'b0; start = 1'b1;
    tick();
    t0 = cyc;
    repeat (14) tick();
    start = 1'b0;
    wait_done(2, "period14 done timeout");
    repeat (3) tick();
    exp  = model_msg(8'h04, 8'h05, 8'h06, 1'b0, 1'b1, 8'h0A);
    exp2 = exp;
    foreach (exp[i]) exp2.push_back(exp[i]);
    check_q("period14 bytes", qb, exp2);
    check_val("period14 first done", 32'(first_done_lat(t0)), 32'd12);
    check_val("period14 gap",
              32'((done_cycs_b.size() == 2) ? done_cycs_b[1] - done_cycs_b[0] : -1), 32'd14);

    // Reset after byte 4 is accepted, with start high in the same cycle.
    clear_mon();
    tx_ready = 1'b1;
    launch(8'h08, 8'h15, 8'h42, 1'b1, t0);
    repeat (5) tick();
    reset = 1'b1; start = 1'b1; tx_ready = 1'b0;
    tick();
    check_val("abort outputs", {ifb.tx_valid, ifb.tx_data, busy_b, ifz.tx_valid, busy_z}, 32'd0);
    reset = 1'b0; start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tx_ready = 1'($urandom);
      tick();
    end
    exp = model_msg(8'h08, 8'h15, 8'h42, 1'b1, 1'b1, 8'h0A);
    exp = exp[0:4];
    check_q("abort partial bytes", qb, exp);
    check_val("abort no done", 32'(done_cnt_b + done_cnt_z), 32'd0);
    check_val("abort idle", {busy_b, ifb.tx_valid}, 32'd0);

    clear_mon();
    tx_ready = 1'b1;
    launch(8'h12, 8'h59, 8'h59, 1'b1, t0);
    wait_done(1, "after-abort done timeout");
    repeat (3) tick();
    check_q("after-abort bytes", qb, model_msg(8'h12, 8'h59, 8'h59, 1'b1, 1'b1, 8'h0A));
    check_val("after-abort done latency", 32'(first_done_lat(t0)), 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
